// File: rtl/pixel_out_fifo.sv
// pixel_out_fifo: show-ahead pixel FIFO after the gamma LUT; generates the pipeline-wide stall.
// Latency: a pixel pushed at edge N is on out_data/out_valid after edge N. There is no empty bypass.
// Backpressure: datapath_ready = (count < DEPTH), decoded from the count register only. Option macro: PIXEL_FIFO_WATERMARK_EN.

package pixel_out_fifo_pkg;
    typedef logic [7:0] color_t;
endpackage

module pixel_out_fifo
    import pixel_out_fifo_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             datapath_resetN,
    input  color_t           color_in,
    input  logic             color_in_valid,
    output logic             datapath_ready,
    output color_t           out_data,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef PIXEL_FIFO_WATERMARK_EN
    input  logic             wm_clear,
    output logic [CNT_W-1:0] fifo_max_level,
`endif
    output logic [CNT_W-1:0] fifo_level
);

    localparam int PTR_W = $clog2(DEPTH);

    logic             arst_n;
    logic             push;
    logic             pop;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    color_t           mem_q [DEPTH];

    // Either reset flushes the FIFO; the datapath reset must act without waiting for a clock edge.
    assign arst_n = resetN & datapath_resetN;

    assign datapath_ready = (count_q < CNT_W'(DEPTH));
    assign out_valid      = (count_q != '0);
    assign out_data       = mem_q[rd_ptr_q];
    assign fifo_level     = count_q;

    assign push = color_in_valid & datapath_ready;
    assign pop  = out_valid & out_ready;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately not reset; out_valid gates it.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= color_in;
        end
    end

`ifdef PIXEL_FIFO_WATERMARK_EN
    logic [CNT_W-1:0] max_q, max_d;

    always_comb begin
        max_d = max_q;
        if (wm_clear) begin
            max_d = count_q;
        end else if (count_d > max_q) begin
            max_d = count_d;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            max_q <= '0;
        end else begin
            max_q <= max_d;
        end
    end

    assign fifo_max_level = max_q;
`endif

endmodule

// File: tb/tb_pixel_out_fifo.sv
// Bench for pixel_out_fifo: randomized pixel streams checked against a queue model of the FIFO.
module tb_pixel_out_fifo;

    localparam int DEPTH = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             resetN;
    logic             datapath_resetN;
    logic [7:0]       color_in;
    logic             color_in_valid;
    logic             datapath_ready;
    logic [7:0]       out_data;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] fifo_level;
`ifdef PIXEL_FIFO_WATERMARK_EN
    logic             wm_clear;
    logic [CNT_W-1:0] fifo_max_level;
`endif

    int         tests = 0;
    int         fails = 0;
    logic [7:0] mq[$];

    always #5 clk = ~clk;

    pixel_out_fifo #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .resetN         (resetN),
        .datapath_resetN(datapath_resetN),
        .color_in       (color_in),
        .color_in_valid (color_in_valid),
        .datapath_ready (datapath_ready),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
`ifdef PIXEL_FIFO_WATERMARK_EN
        .wm_clear       (wm_clear),
        .fifo_max_level (fifo_max_level),
`endif
        .fifo_level     (fifo_level)
    );

    // Drive one cycle from a negedge and advance the queue model across the posedge.
    task automatic step(input logic v, input logic [7:0] d, input logic r,
                        output bit pushed, output bit popped);
        color_in_valid = v;
        color_in       = d;
        out_ready      = r;
        pushed = v && (mq.size() < DEPTH);
        popped = r && (mq.size() != 0);
        @(posedge clk);
        if (popped) void'(mq.pop_front());
        if (pushed) mq.push_back(d);
        @(negedge clk);
    endtask

    task automatic test_reset;
        resetN = 1'b0; datapath_resetN = 1'b1;
        color_in_valid = 1'b0; color_in = 8'h00; out_ready = 1'b0;
        mq.delete();
        repeat (3) @(negedge clk);
        tests++;
        if ({out_valid, datapath_ready, fifo_level} !== {1'b0, 1'b1, 4'd0}) begin
            fails++;
            $display("FAIL reset_hold: v/r/lvl got %b/%b/%0d want 0/1/0", out_valid, datapath_ready, fifo_level);
        end
        resetN = 1'b1;
        @(negedge clk);
        tests++;
        if ({out_valid, datapath_ready, fifo_level} !== {1'b0, 1'b1, 4'd0}) begin
            fails++;
            $display("FAIL reset_release: v/r/lvl got %b/%b/%0d want 0/1/0", out_valid, datapath_ready, fifo_level);
        end
    endtask

    task automatic test_passthrough;
        bit pu, po;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 8'(8'h10 + i), 1'b1, pu, po);
            tests++;
            if ({out_valid, datapath_ready, fifo_level, out_data} !== {1'b1, 1'b1, 4'd1, 8'(8'h10 + i)}) begin
                fails++;
                $display("FAIL passthrough[%0d]: v/r/lvl/data got %b/%b/%0d/%h want 1/1/1/%h",
                         i, out_valid, datapath_ready, fifo_level, out_data, 8'(8'h10 + i));
            end
        end
        step(1'b0, 8'h00, 1'b1, pu, po);
        tests++;
        if ({out_valid, datapath_ready, fifo_level} !== {1'b0, 1'b1, 4'd0}) begin
            fails++;
            $display("FAIL passthrough_drain: v/r/lvl got %b/%b/%0d want 0/1/0", out_valid, datapath_ready, fifo_level);
        end
    endtask

    task automatic test_backpressure;
        bit pu, po;
        int idx = 0;
        int got = 0;
        for (int c = 0; c < 12; c++) begin
            step(1'b1, 8'(8'h20 + idx), 1'b0, pu, po);
            if (pu) idx++;
            tests++;
            if ({out_valid, datapath_ready, fifo_level} !== {mq.size() != 0, mq.size() < DEPTH, 4'(mq.size())}) begin
                fails++;
                $display("FAIL bp_fill[%0d]: v/r/lvl got %b/%b/%0d want %b/%b/%0d", c, out_valid, datapath_ready,
                         fifo_level, mq.size() != 0, mq.size() < DEPTH, mq.size());
            end
        end
        tests++;
        if ({idx, fifo_level, datapath_ready} !== {32'd8, 4'd8, 1'b0}) begin
            fails++;
            $display("FAIL bp_full: captured/lvl/rdy got %0d/%0d/%b want 8/8/0", idx, fifo_level, datapath_ready);
        end
        for (int c = 0; c < 40 && got < 10; c++) begin
            if (mq.size() != 0) begin
                tests++;
                if (out_valid !== 1'b1 || out_data !== 8'(8'h20 + got)) begin
                    fails++;
                    $display("FAIL bp_order[%0d]: v/data got %b/%h want 1/%h", got, out_valid, out_data, 8'(8'h20 + got));
                end
            end
            step(idx < 10, 8'(8'h20 + idx), 1'b1, pu, po);
            if (pu) idx++;
            if (po) got++;
            tests++;
            if ({out_valid, datapath_ready, fifo_level} !== {mq.size() != 0, mq.size() < DEPTH, 4'(mq.size())}) begin
                fails++;
                $display("FAIL bp_drain[%0d]: v/r/lvl got %b/%b/%0d want %b/%b/%0d", c, out_valid, datapath_ready,
                         fifo_level, mq.size() != 0, mq.size() < DEPTH, mq.size());
            end
        end
        tests++;
        if (got != 10 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL bp_count: popped/v got %0d/%b want 10/0", got, out_valid);
        end
    endtask

    task automatic test_full_pop;
        bit pu, po;
        for (int c = 0; c < 20 && mq.size() < DEPTH; c++) begin
            step(1'b1, 8'($urandom), 1'b0, pu, po);
        end
        step(1'b1, 8'hEE, 1'b1, pu, po);
        tests++;
        if ({fifo_level, datapath_ready, pu} !== {4'd7, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL full_pop: lvl/rdy/model_push got %0d/%b/%b want 7/1/0", fifo_level, datapath_ready, pu);
        end
        step(1'b1, 8'hEF, 1'b0, pu, po);
        tests++;
        if ({fifo_level, datapath_ready} !== {4'd8, 1'b0}) begin
            fails++;
            $display("FAIL full_refill: lvl/rdy got %0d/%b want 8/0", fifo_level, datapath_ready);
        end
        for (int c = 0; c < 20 && mq.size() != 0; c++) begin
            tests++;
            if (out_valid !== 1'b1 || out_data !== mq[0]) begin
                fails++;
                $display("FAIL full_drain[%0d]: v/data got %b/%h want 1/%h", c, out_valid, out_data, mq[0]);
            end
            step(1'b0, 8'h00, 1'b1, pu, po);
        end
        tests++;
        if ({out_valid, fifo_level} !== {1'b0, 4'd0}) begin
            fails++;
            $display("FAIL full_empty: v/lvl got %b/%0d want 0/0", out_valid, fifo_level);
        end
    endtask

    task automatic test_wrap;
        bit pu, po;
        int sent = 0;
        int got = 0;
        logic v;
        for (int c = 0; c < 400 && got < 3 * DEPTH; c++) begin
            if (mq.size() != 0) begin
                tests++;
                if (out_valid !== 1'b1 || out_data !== 8'(8'hA0 + got)) begin
                    fails++;
                    $display("FAIL wrap_order[%0d]: v/data got %b/%h want 1/%h", got, out_valid, out_data, 8'(8'hA0 + got));
                end
            end
            v = (c % 2 == 0) && (sent < 3 * DEPTH);
            step(v, v ? 8'(8'hA0 + sent) : 8'($urandom), 1'($urandom_range(0, 1)), pu, po);
            if (pu) sent++;
            if (po) got++;
            tests++;
            if ({out_valid, datapath_ready, fifo_level} !== {mq.size() != 0, mq.size() < DEPTH, 4'(mq.size())}) begin
                fails++;
                $display("FAIL wrap_state[%0d]: v/r/lvl got %b/%b/%0d want %b/%b/%0d", c, out_valid, datapath_ready,
                         fifo_level, mq.size() != 0, mq.size() < DEPTH, mq.size());
            end
        end
        tests++;
        if (got != 3 * DEPTH || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL wrap_count: popped/v got %0d/%b want %0d/0", got, out_valid, 3 * DEPTH);
        end
    endtask

    task automatic test_datapath_reset;
        bit pu, po;
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h30 + i), 1'b0, pu, po);
        tests++;
        if ({fifo_level, out_data} !== {4'd5, 8'h30}) begin
            fails++;
            $display("FAIL dpr_fill: lvl/data got %0d/%h want 5/30", fifo_level, out_data);
        end
        color_in_valid = 1'b0;
        #2 datapath_resetN = 1'b0;
        #1;
        mq.delete();
        tests++;
        if ({out_valid, datapath_ready, fifo_level} !== {1'b0, 1'b1, 4'd0}) begin
            fails++;
            $display("FAIL dpr_async: v/r/lvl got %b/%b/%0d want 0/1/0", out_valid, datapath_ready, fifo_level);
        end
        #1 datapath_resetN = 1'b1;
        @(negedge clk);
        step(1'b1, 8'h55, 1'b1, pu, po);
        tests++;
        if ({out_valid, fifo_level, out_data} !== {1'b1, 4'd1, 8'h55}) begin
            fails++;
            $display("FAIL dpr_next: v/lvl/data got %b/%0d/%h want 1/1/55", out_valid, fifo_level, out_data);
        end
        step(1'b0, 8'h00, 1'b1, pu, po);
        tests++;
        if ({out_valid, fifo_level} !== {1'b0, 4'd0}) begin
            fails++;
            $display("FAIL dpr_drain: v/lvl got %b/%0d want 0/0", out_valid, fifo_level);
        end
    endtask

`ifdef PIXEL_FIFO_WATERMARK_EN
    task automatic test_watermark;
        bit pu, po;
        wm_clear = 1'b0;
        #2 datapath_resetN = 1'b0;
        #2 datapath_resetN = 1'b1;
        mq.delete();
        @(negedge clk);
        tests++;
        if (fifo_max_level !== 4'd0) begin
            fails++;
            $display("FAIL wm_reset: max got %0d want 0", fifo_max_level);
        end
        for (int i = 0; i < 6; i++) step(1'b1, 8'($urandom), 1'b0, pu, po);
        for (int c = 0; c < 20 && mq.size() != 0; c++) step(1'b0, 8'h00, 1'b1, pu, po);
        tests++;
        if ({fifo_max_level, fifo_level} !== {4'd6, 4'd0}) begin
            fails++;
            $display("FAIL wm_peak: max/lvl got %0d/%0d want 6/0", fifo_max_level, fifo_level);
        end
        for (int i = 0; i < 2; i++) step(1'b1, 8'($urandom), 1'b0, pu, po);
        wm_clear = 1'b1;
        step(1'b0, 8'h00, 1'b0, pu, po);
        wm_clear = 1'b0;
        tests++;
        if ({fifo_max_level, fifo_level} !== {4'd2, 4'd2}) begin
            fails++;
            $display("FAIL wm_clear: max/lvl got %0d/%0d want 2/2", fifo_max_level, fifo_level);
        end
    endtask
`endif

    initial begin
`ifdef PIXEL_FIFO_WATERMARK_EN
        wm_clear = 1'b0;
`endif
        test_reset();
        test_passthrough();
        test_backpressure();
        test_full_pop();
        test_wrap();
        test_datapath_reset();
`ifdef PIXEL_FIFO_WATERMARK_EN
        test_watermark();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded 200000 time units");
        $fatal(1, "timeout");
    end

endmodule
